// File: rtl/am9511_stack_unit_if.sv
// Handshake/bus bundle for am9511_stack_unit: push/pop, command, executor issue/result, completion.
// slave = stack unit view, master = host/executor view.
interface am9511_stack_unit_if #(
    parameter int DATA_W      = 64,
    parameter int STACK_DEPTH = 8
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_func;
    logic [7:0]        cmd_fmt;
    logic [1:0]        cmd_rm;
    logic              exe_valid;
    logic              exe_ready;
    logic [7:0]        exe_func;
    logic [7:0]        exe_fmt;
    logic [63:0]       exe_op0;
    logic [63:0]       exe_op1;
    logic [63:0]       exe_op2;
    logic [1:0]        exe_rm;
    logic              exe_res_valid;
    logic [DATA_W-1:0] exe_res_data;
    logic [15:0]       exe_res_status;
    logic [31:0]       exe_res_flags;
    logic              done_valid;
    logic [15:0]       done_status;
    logic [31:0]       done_flags;
    logic [DW-1:0]     depth;
    logic              overflow;
    logic              busy;

    modport slave (
        input  push_valid, push_data, pop_ready,
        input  cmd_valid, cmd_func, cmd_fmt, cmd_rm,
        input  exe_ready, exe_res_valid, exe_res_data, exe_res_status, exe_res_flags,
        output push_ready, pop_valid, pop_data, cmd_ready,
        output exe_valid, exe_func, exe_fmt, exe_op0, exe_op1, exe_op2, exe_rm,
        output done_valid, done_status, done_flags, depth, overflow, busy
    );

    modport master (
        output push_valid, push_data, pop_ready,
        output cmd_valid, cmd_func, cmd_fmt, cmd_rm,
        output exe_ready, exe_res_valid, exe_res_data, exe_res_status, exe_res_flags,
        input  push_ready, pop_valid, pop_data, cmd_ready,
        input  exe_valid, exe_func, exe_fmt, exe_op0, exe_op1, exe_op2, exe_rm,
        input  done_valid, done_status, done_flags, depth, overflow, busy
    );
endinterface

// File: rtl/am9511_stack_unit.sv
// Am9511-style circular operand stack feeding an external am9513 executor.
// Optional local DUP/SWAP/DROP ops enabled by defining AM9511_STACK_OPS_EN.
module am9511_stack_unit #(
    parameter int          STACK_DEPTH = 8,
    parameter int          DATA_W      = 64,
    parameter logic [31:0] FMT_MASK    = 32'h1
) (
    input logic                clk,
    input logic                rst_n,
    am9511_stack_unit_if.slave bus
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_WB       = 3'd3;
    localparam logic [2:0] S_DONE_ERR = 3'd4;

    localparam logic [7:0] FUNC_ADD  = 8'h01;
    localparam logic [7:0] FUNC_SUB  = 8'h02;
    localparam logic [7:0] FUNC_MUL  = 8'h03;
    localparam logic [7:0] FUNC_DIV  = 8'h04;
    localparam logic [7:0] FUNC_SQRT = 8'h05;
    localparam logic [7:0] FUNC_SIN  = 8'h06;
    localparam logic [7:0] FUNC_FMA  = 8'h07;
    localparam logic [7:0] FUNC_DUP  = 8'hF0;
    localparam logic [7:0] FUNC_SWAP = 8'hF1;
    localparam logic [7:0] FUNC_DROP = 8'hF2;

    localparam logic [15:0] ST_OK         = 16'h0000;
    localparam logic [15:0] ST_INVALID_OP = 16'h0001;

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]     top;
    logic [DW-1:0]     depth_q;
    logic              overflow_q;
    logic [2:0]        state;

    logic [7:0]  iss_func, iss_fmt;
    logic [1:0]  iss_rm, iss_arity;
    logic [63:0] iss_op0, iss_op1, iss_op2;
    logic        done_q;
    logic [15:0] status_q;
    logic [31:0] flags_q;

    logic              idle, full, push_fire, pop_fire, accept, fmt_ok, known, legal_exe;
    logic [1:0]        arity;
    logic [PW-1:0]     top_inc, top_dec, top_dec2, wb_top;
    logic [DATA_W-1:0] tos, nos, third;

    assign idle      = (state == S_IDLE);
    assign full      = (depth_q == DW'(STACK_DEPTH));
    assign top_inc   = top + PW'(1);
    assign top_dec   = top - PW'(1);
    assign top_dec2  = top - PW'(2);
    assign wb_top    = top - PW'(iss_arity) + PW'(1);
    assign tos       = mem[top];
    assign nos       = mem[top_dec];
    assign third     = mem[top_dec2];
    assign accept    = bus.cmd_valid & idle;
    assign push_fire = bus.push_valid & bus.push_ready;
    assign pop_fire  = bus.pop_valid & bus.pop_ready;
    assign fmt_ok    = (bus.cmd_fmt < 8'd32) && FMT_MASK[bus.cmd_fmt[4:0]];

    always_comb begin
        known = 1'b1;
        arity = 2'd0;
        case (bus.cmd_func)
            FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV: arity = 2'd2;
            FUNC_SQRT, FUNC_SIN:                    arity = 2'd1;
            FUNC_FMA:                               arity = 2'd3;
            default:                                known = 1'b0;
        endcase
    end
    assign legal_exe = known & fmt_ok & (depth_q >= DW'(arity));

`ifdef AM9511_STACK_OPS_EN
    logic local_ok;
    always_comb begin
        local_ok = 1'b0;
        case (bus.cmd_func)
            FUNC_DUP, FUNC_DROP: local_ok = (depth_q >= DW'(1));
            FUNC_SWAP:           local_ok = (depth_q >= DW'(2));
            default:             local_ok = 1'b0;
        endcase
    end
`endif

    assign bus.cmd_ready   = idle;
    assign bus.push_ready  = idle & ~bus.cmd_valid;
    assign bus.pop_valid   = idle & (depth_q != '0) & ~bus.cmd_valid;
    assign bus.pop_data    = (depth_q != '0) ? tos : '0;
    assign bus.exe_valid   = (state == S_ISSUE);
    assign bus.exe_func    = iss_func;
    assign bus.exe_fmt     = iss_fmt;
    assign bus.exe_rm      = iss_rm;
    assign bus.exe_op0     = iss_op0;
    assign bus.exe_op1     = iss_op1;
    assign bus.exe_op2     = iss_op2;
    assign bus.done_valid  = done_q;
    assign bus.done_status = status_q;
    assign bus.done_flags  = flags_q;
    assign bus.depth       = depth_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = ~idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
            top <= '0;       depth_q <= '0;   overflow_q <= 1'b0; state <= S_IDLE;
            iss_func <= '0;  iss_fmt <= '0;   iss_rm <= '0;       iss_arity <= '0;
            iss_op0 <= '0;   iss_op1 <= '0;   iss_op2 <= '0;
            done_q <= 1'b0;  status_q <= '0;  flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (legal_exe) begin
                            // Operand order: deepest operand first, TOS last.
                            iss_func  <= bus.cmd_func;
                            iss_fmt   <= bus.cmd_fmt;
                            iss_rm    <= bus.cmd_rm;
                            iss_arity <= arity;
                            iss_op0   <= (arity == 2'd3) ? 64'(third) : (arity == 2'd2) ? 64'(nos) : 64'(tos);
                            iss_op1   <= (arity == 2'd3) ? 64'(nos) : (arity == 2'd2) ? 64'(tos) : '0;
                            iss_op2   <= (arity == 2'd3) ? 64'(tos) : '0;
                            state     <= S_ISSUE;
`ifdef AM9511_STACK_OPS_EN
                        end else if (local_ok) begin
                            case (bus.cmd_func)
                                FUNC_DUP: begin
                                    top          <= top_inc;
                                    mem[top_inc] <= tos;
                                    if (full) overflow_q <= 1'b1;
                                    else      depth_q    <= depth_q + DW'(1);
                                end
                                FUNC_SWAP: begin
                                    mem[top]     <= nos;
                                    mem[top_dec] <= tos;
                                end
                                default: begin
                                    top     <= top_dec;
                                    depth_q <= depth_q - DW'(1);
                                end
                            endcase
                            done_q   <= 1'b1;
                            status_q <= ST_OK;
                            flags_q  <= '0;
                            state    <= S_DONE_ERR;
`endif
                        end else begin
                            done_q   <= 1'b1;
                            status_q <= ST_INVALID_OP;
                            flags_q  <= '0;
                            state    <= S_DONE_ERR;
                        end
                    end else if (push_fire && pop_fire) begin
                        mem[top] <= bus.push_data;
                    end else if (push_fire) begin
                        // Wrapping the pointer onto the oldest slot gives circular overwrite.
                        top          <= top_inc;
                        mem[top_inc] <= bus.push_data;
                        if (full) overflow_q <= 1'b1;
                        else      depth_q    <= depth_q + DW'(1);
                    end else if (pop_fire) begin
                        top     <= top_dec;
                        depth_q <= depth_q - DW'(1);
                    end
                end
                S_ISSUE: if (bus.exe_ready) state <= S_WAIT;
                S_WAIT: begin
                    if (bus.exe_res_valid) begin
                        mem[wb_top] <= bus.exe_res_data;
                        top         <= wb_top;
                        depth_q     <= depth_q - DW'(iss_arity) + DW'(1);
                        done_q      <= 1'b1;
                        status_q    <= bus.exe_res_status;
                        flags_q     <= bus.exe_res_flags;
                        state       <= S_WB;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_am9511_stack_unit.sv
// Scoreboard bench for am9511_stack_unit: stimulus queues expected issues/pops/completions,
// a negedge monitor pops and compares them whenever the DUT presents the matching output.
module tb_am9511_stack_unit;
    localparam logic [7:0] ADD = 8'h01, SUB = 8'h02, MUL = 8'h03, DIV = 8'h04;
    localparam logic [7:0] SQRT = 8'h05, FMA = 8'h07;
    localparam logic [7:0] DUP = 8'hF0, SWAP = 8'hF1, DROP = 8'hF2;
    localparam logic [15:0] OK = 16'h0000, INV = 16'h0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    am9511_stack_unit_if #(.DATA_W(64), .STACK_DEPTH(8)) bus ();

    am9511_stack_unit #(.STACK_DEPTH(8), .DATA_W(64), .FMT_MASK(32'h1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        string       name;
        logic [15:0] status;
        logic [31:0] flags;
        logic [3:0]  depth;
        int          lat;
    } done_t;

    typedef struct {
        string       name;
        logic [7:0]  func;
        logic [7:0]  fmt;
        logic [1:0]  rm;
        logic [63:0] op0, op1, op2;
    } iss_t;

    done_t       dq[$];
    iss_t        iq[$];
    logic [63:0] pq[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: output presented with nothing expected", name);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done_valid) begin
                if (dq.size() == 0) unexpected("done");
                else begin
                    done_t d;
                    d = dq.pop_front();
                    chk({d.name, "_status"}, 64'(bus.done_status), 64'(d.status));
                    chk({d.name, "_flags"},  64'(bus.done_flags),  64'(d.flags));
                    chk({d.name, "_depth"},  64'(bus.depth),       64'(d.depth));
                    if (d.lat != 0) chk({d.name, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(d.lat));
                end
            end
            if (bus.exe_valid) begin
                if (iq.size() == 0) unexpected("exe_valid");
                else begin
                    iss_t e;
                    e = iq[0];
                    chk({e.name, "_func"}, 64'(bus.exe_func), 64'(e.func));
                    chk({e.name, "_fmt"},  64'(bus.exe_fmt),  64'(e.fmt));
                    chk({e.name, "_rm"},   64'(bus.exe_rm),   64'(e.rm));
                    chk({e.name, "_op0"},  bus.exe_op0, e.op0);
                    chk({e.name, "_op1"},  bus.exe_op1, e.op1);
                    chk({e.name, "_op2"},  bus.exe_op2, e.op2);
                    if (bus.exe_ready) void'(iq.pop_front());
                end
            end
            if (bus.pop_valid && bus.pop_ready) begin
                if (pq.size() == 0) unexpected("pop");
                else chk("pop_data", bus.pop_data, pq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_done(input string n, input logic [15:0] st, input logic [31:0] fl,
                            input logic [3:0] dep, input int lat);
        done_t d;
        d.name = n; d.status = st; d.flags = fl; d.depth = dep; d.lat = lat;
        dq.push_back(d);
    endtask

    task automatic exp_iss(input string n, input logic [7:0] f, input logic [7:0] fm, input logic [1:0] rm,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        iss_t e;
        e.name = n; e.func = f; e.fmt = fm; e.rm = rm; e.op0 = a; e.op1 = b; e.op2 = c;
        iq.push_back(e);
    endtask

    task automatic push(input logic [63:0] v);
        bus.push_valid = 1'b1;
        bus.push_data  = v;
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic pop(input logic [63:0] exp);
        bit ok;
        ok = 1'b0;
        pq.push_back(exp);
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.pop_valid) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        bus.pop_ready = 1'b0;
        if (!ok) begin
            void'(pq.pop_back());
            unexpected("pop_timeout");
        end
    endtask

    task automatic pushpop(input logic [63:0] v, input logic [63:0] exp);
        pq.push_back(exp);
        bus.push_valid = 1'b1;
        bus.push_data  = v;
        bus.pop_ready  = 1'b1;
        step();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] f, input logic [7:0] fm, input logic [1:0] rm);
        bus.cmd_valid = 1'b1;
        bus.cmd_func  = f;
        bus.cmd_fmt   = fm;
        bus.cmd_rm    = rm;
        step();
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    // Executor stand-in; a stall first pulses a stray result that must be ignored outside WAIT.
    task automatic exec(input logic [63:0] res, input logic [15:0] st, input logic [31:0] fl, input int stall);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.exe_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) unexpected("exe_timeout");
        else begin
            if (stall > 0) begin
                bus.exe_ready      = 1'b0;
                bus.exe_res_valid  = 1'b1;
                bus.exe_res_data   = 64'hDEAD;
                bus.exe_res_status = 16'hFFFF;
                step();
                bus.exe_res_valid  = 1'b0;
                for (int i = 1; i < stall; i++) step();
                bus.exe_ready = 1'b1;
            end
            step();
            bus.exe_res_valid  = 1'b1;
            bus.exe_res_data   = res;
            bus.exe_res_status = st;
            bus.exe_res_flags  = fl;
            step();
            bus.exe_res_valid  = 1'b0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_valid = 0; bus.push_data = '0; bus.pop_ready = 0;
        bus.cmd_valid = 0;  bus.cmd_func = '0;  bus.cmd_fmt = '0; bus.cmd_rm = '0;
        bus.exe_ready = 1;  bus.exe_res_valid = 0; bus.exe_res_data = '0;
        bus.exe_res_status = '0; bus.exe_res_flags = '0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        chk("rst_depth", 64'(bus.depth), 0);
        chk("rst_overflow", 64'(bus.overflow), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done_valid", 64'(bus.done_valid), 0);
        chk("rst_pop_valid", 64'(bus.pop_valid), 0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 1);

        // SUB 2.0f - 3.0f
        push(64'h4000_0000);
        push(64'h4040_0000);
        exp_iss("sub", SUB, 8'd0, 2'b00, 64'h4000_0000, 64'h4040_0000, 64'd0);
        exp_done("sub", OK, 32'h5, 4'd1, 3);
        cmd(SUB, 8'd0, 2'b00);
        exec(64'hBF80_0000, OK, 32'h5, 0);
        pop(64'hBF80_0000);

        // underflow / illegal fmt / illegal func / fmt beyond 31
        push(64'd7);
        exp_done("add_underflow", INV, 32'h0, 4'd1, 1);
        cmd(ADD, 8'd0, 2'b00); step();
        push(64'd8);
        exp_done("mul_b64", INV, 32'h0, 4'd2, 1);
        cmd(MUL, 8'd1, 2'b00); step();
        exp_done("bad_func", INV, 32'h0, 4'd2, 1);
        cmd(8'h55, 8'd0, 2'b00); step();
        exp_done("fmt40", INV, 32'h0, 4'd2, 1);
        cmd(ADD, 8'd40, 2'b00); step();

        // DIV with stalled executor and error status still written back
        exp_iss("div", DIV, 8'd0, 2'b11, 64'd7, 64'd8, 64'd0);
        exp_done("div", 16'h0004, 32'h1, 4'd1, 0);
        bus.exe_ready = 1'b0;
        cmd(DIV, 8'd0, 2'b11);
        exec(64'd99, 16'h0004, 32'h1, 5);

        // FMA depth 3 -> 1
        push(64'd10);
        push(64'd11);
        exp_iss("fma", FMA, 8'd0, 2'b01, 64'd99, 64'd10, 64'd11);
        exp_done("fma", OK, 32'h0, 4'd1, 3);
        cmd(FMA, 8'd0, 2'b01);
        exec(64'd1234, OK, 32'h0, 0);
        pop(64'd1234);

        exp_done("sqrt_empty", INV, 32'h0, 4'd0, 1);
        cmd(SQRT, 8'd0, 2'b00); step();
        push(64'd25);
        exp_iss("sqrt", SQRT, 8'd0, 2'b10, 64'd25, 64'd0, 64'd0);
        exp_done("sqrt", OK, 32'h10, 4'd1, 3);
        cmd(SQRT, 8'd0, 2'b10);
        exec(64'd5, OK, 32'h10, 0);
        pop(64'd5);

`ifdef AM9511_STACK_OPS_EN
        push(64'hA);
        push(64'hB);
        exp_done("swap", OK, 32'h0, 4'd2, 1);
        cmd(SWAP, 8'd0, 2'b00); step();
        pop(64'hA);
        pop(64'hB);
        exp_done("drop_empty", INV, 32'h0, 4'd0, 1);
        cmd(DROP, 8'd0, 2'b00); step();
        push(64'd3);
        exp_done("dup", OK, 32'h0, 4'd2, 1);
        cmd(DUP, 8'h77, 2'b00); step();
        pop(64'd3);
        pop(64'd3);
`else
        push(64'd3);
        exp_done("f0_illegal", INV, 32'h0, 4'd1, 1);
        cmd(DUP, 8'd0, 2'b00); step();
        pop(64'd3);
`endif

        // overflow: 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++) push(64'(i));
        chk("ovf_depth", 64'(bus.depth), 8);
        chk("ovf_flag", 64'(bus.overflow), 1);
        for (int i = 9; i >= 2; i--) pop(64'(i));
        chk("ovf_drained", 64'(bus.depth), 0);
        push(64'd5);
        push(64'd6);
        pushpop(64'd7, 64'd6);
        chk("pushpop_depth", 64'(bus.depth), 2);
        pop(64'd7);
        pop(64'd5);
        chk("sticky_overflow", 64'(bus.overflow), 1);

        // reset while waiting on the executor
        push(64'd1);
        push(64'd2);
        exp_iss("add_rst", ADD, 8'd0, 2'b00, 64'd1, 64'd2, 64'd0);
        cmd(ADD, 8'd0, 2'b00);
        step(); step();
        chk("wait_busy", 64'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_depth", 64'(bus.depth), 0);
        chk("arst_overflow", 64'(bus.overflow), 0);
        chk("arst_busy", 64'(bus.busy), 0);
        chk("arst_exe_valid", 64'(bus.exe_valid), 0);
        chk("arst_exe_op0", bus.exe_op0, 0);
        chk("arst_exe_func", 64'(bus.exe_func), 0);
        chk("arst_done_status", 64'(bus.done_status), 0);
        chk("arst_done_flags", 64'(bus.done_flags), 0);
        chk("arst_pop_data", bus.pop_data, 0);
        step();
        rst_n = 1'b1;
        bus.exe_res_valid = 1'b1;
        bus.exe_res_data  = 64'd3;
        step();
        bus.exe_res_valid = 1'b0;
        step();
        chk("post_rst_depth", 64'(bus.depth), 0);
        chk("post_rst_busy", 64'(bus.busy), 0);

        chk("done_queue_empty", 64'(dq.size()), 0);
        chk("issue_queue_empty", 64'(iq.size()), 0);
        chk("pop_queue_empty", 64'(pq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
